// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Brief    : Shared helpers for the synchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    function automatic int f_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, registered read data, full/empty, sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  overflow
);

    localparam int ADDR_WIDTH = f_clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [ADDR_WIDTH-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [ADDR_WIDTH:0]   r_count_q,  r_count_d;
    logic [DATA_WIDTH-1:0] r_rd_data_q;
    logic                  r_overflow_q, r_overflow_d;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;

    assign w_full  = (r_count_q == c_CNT_FULL);
    assign w_empty = (r_count_q == '0);

    // A write into a full FIFO is only legal when a read frees the slot this cycle.
    assign w_wr_accept = wr_en && (!w_full || rd_en);
    assign w_rd_accept = rd_en && !w_empty;

    always_comb begin
        r_wr_ptr_d   = r_wr_ptr_q;
        r_rd_ptr_d   = r_rd_ptr_q;
        r_count_d    = r_count_q;
        r_overflow_d = r_overflow_q;

        if (w_wr_accept) begin
            r_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        end
        if (w_rd_accept) begin
            r_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        end

        case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count_d = r_count_q + c_CNT_ONE;
            2'b01:   r_count_d = r_count_q - c_CNT_ONE;
            default: r_count_d = r_count_q;
        endcase

        if (wr_en && w_full && !rd_en) begin
            r_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_rd_data_q  <= '0;
            r_overflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q   <= r_wr_ptr_d;
            r_rd_ptr_q   <= r_rd_ptr_d;
            r_count_q    <= r_count_d;
            r_overflow_q <= r_overflow_d;
            if (w_rd_accept) begin
                r_rd_data_q <= r_mem[r_rd_ptr_q];
            end
        end
    end

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !rst) begin
            r_mem[r_wr_ptr_q] <= wr_data;
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign rd_data  = r_rd_data_q;
    assign overflow = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Self-checking bench for sync_fifo (DEPTH=4) against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int DW = 16;
    localparam int DP = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          overflow;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: contents as a queue, plus the two visible registers.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_ovf;

    typedef struct {
        bit          wr;
        bit [DW-1:0] wd;
        bit          rd;
        bit          full;
        bit          empty;
        bit          ovf;
        bit [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".full"},     32'(full),     32'(m_q.size() == DP));
        chk({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(m_rd_data));
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input string tag);
        bit was_full;
        bit was_empty;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        was_full  = (m_q.size() == DP);
        was_empty = (m_q.size() == 0);
        @(posedge clk);
        if (rd && !was_empty) m_rd_data = m_q.pop_front();
        if (wr && (!was_full || rd)) m_q.push_back(wd);
        if (wr && was_full && !rd) m_ovf = 1'b1;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset(input bit wr_noise, input bit rd_noise, input string tag);
        rst     = 1'b1;
        wr_en   = wr_noise;
        rd_en   = rd_noise;
        wr_data = 16'hDEAD;
        @(posedge clk);
        m_q.delete();
        m_rd_data = '0;
        m_ovf     = 1'b0;
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk({tag, ".empty"},    32'(empty),    32'h1);
        chk({tag, ".full"},     32'(full),     32'h0);
        chk({tag, ".overflow"}, 32'(overflow), 32'h0);
        chk({tag, ".rd_data"},  32'(rd_data),  32'h0);
    endtask

    initial begin
        // wr, wd, rd, full, empty, ovf, rd_data  (state visible after the edge)
        vecs[0]  = '{1, 16'h0011, 0, 0, 0, 0, 16'h0000};
        vecs[1]  = '{1, 16'h0022, 0, 0, 0, 0, 16'h0000};
        vecs[2]  = '{1, 16'h0033, 0, 0, 0, 0, 16'h0000};
        vecs[3]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0011};
        vecs[4]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0022};
        vecs[5]  = '{0, 16'h0000, 1, 0, 1, 0, 16'h0033};
        vecs[6]  = '{0, 16'h0000, 1, 0, 1, 0, 16'h0033};
        vecs[7]  = '{1, 16'h00AB, 1, 0, 0, 0, 16'h0033};
        vecs[8]  = '{0, 16'h0000, 1, 0, 1, 0, 16'h00AB};
        vecs[9]  = '{1, 16'h00A1, 0, 0, 0, 0, 16'h00AB};
        vecs[10] = '{1, 16'h00A2, 0, 0, 0, 0, 16'h00AB};
        vecs[11] = '{1, 16'h00A3, 0, 0, 0, 0, 16'h00AB};
        vecs[12] = '{1, 16'h00A4, 0, 1, 0, 0, 16'h00AB};
        vecs[13] = '{1, 16'h00A5, 0, 1, 0, 1, 16'h00AB};
        vecs[14] = '{1, 16'h00B1, 1, 1, 0, 1, 16'h00A1};
        vecs[15] = '{0, 16'h0000, 1, 0, 0, 1, 16'h00A2};
        vecs[16] = '{0, 16'h0000, 1, 0, 0, 1, 16'h00A3};
        vecs[17] = '{0, 16'h0000, 1, 0, 0, 1, 16'h00A4};
        vecs[18] = '{0, 16'h0000, 1, 0, 1, 1, 16'h00B1};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        m_rd_data = '0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0, "reset");
        step(1'b0, '0, 1'b0, "idle");

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_full", i),  32'(full),     32'(vecs[i].full));
            chk($sformatf("vec%0d.tbl_empty", i), 32'(empty),    32'(vecs[i].empty));
            chk($sformatf("vec%0d.tbl_ovf", i),   32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d.tbl_rd", i),    32'(rd_data),  32'(vecs[i].rdata));
        end
        step(1'b0, '0, 1'b0, "ovf_sticky");
        chk("ovf_sticky.tbl", 32'(overflow), 32'h1);

        // Full with simultaneous write and read: no overflow, full retained.
        do_reset(1'b1, 1'b1, "reset_prio");
        for (int i = 0; i < DP; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, "fill");
        step(1'b1, 16'h0CFF, 1'b1, "full_rw");
        chk("full_rw.rd",   32'(rd_data),  32'h0C00);
        chk("full_rw.full", 32'(full),     32'h1);
        chk("full_rw.ovf",  32'(overflow), 32'h0);
        for (int i = 0; i < DP; i++) step(1'b0, '0, 1'b1, "drain");
        chk("drain.last", 32'(rd_data), 32'h0CFF);

        // Wrap-around: interleaved write/read pairs with incrementing data.
        step(1'b1, 16'h0100, 1'b0, "wrap_pre");
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b0, "wrap_wr");
            step(1'b0, '0, 1'b1, "wrap_rd");
            chk($sformatf("wrap%0d.order", i), 32'(rd_data), 32'h0100 + 32'(i - 1));
        end

        // Reset mid-stream with pending data.
        step(1'b1, 16'h0777, 1'b0, "mid_wr");
        do_reset(1'b0, 1'b0, "reset_mid");

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit wr;
            bit rd;
            int bias;
            bias = (i / 300) % 3;
            wr = ($urandom_range(0, 99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50)));
            rd = ($urandom_range(0, 99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50)));
            if ($urandom_range(0, 499) == 0) do_reset(wr, rd, "rand_rst");
            else step(wr, 16'($urandom), rd, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
